// File: rtl/mul_prod_accum_pkg.sv
// Shared constants for the product accumulator: FSM state codes and default widths
// common with the upstream multiplier stage.
package mul_prod_accum_pkg;

    localparam int PROD_W_DEF = 8;
    localparam int ACC_W_DEF  = 16;
    localparam int CNT_W_DEF  = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/mul_prod_accum_if.sv
// Job, product and result handshake bundle between the multiplier, the accumulator
// and the result consumer.
interface mul_prod_accum_if
    import mul_prod_accum_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              start;
    logic [CNT_W-1:0]  n_terms;
    logic [PROD_W-1:0] prod;
    logic              prod_valid;
    logic              prod_ready;
    logic              busy;
    logic [ACC_W-1:0]  acc;
    logic              ovf;
    logic              res_valid;
    logic              res_ready;

    modport master (
        output start, n_terms, prod, prod_valid, res_ready,
        input  prod_ready, busy, acc, ovf, res_valid
    );

    modport slave (
        input  start, n_terms, prod, prod_valid, res_ready,
        output prod_ready, busy, acc, ovf, res_valid
    );
endinterface

// File: rtl/mul_acc_add.sv
// ACC_W adder with carry-out. With MUL_ACC_SAT_EN defined the sum clamps to all-ones
// on carry-out; otherwise it wraps modulo 2**ACC_W.
module mul_acc_add #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 16
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              carry
);
    logic [ACC_W:0] full;

    assign full  = {1'b0, acc_in} + {1'b0, ACC_W'(prod)};
    assign carry = full[ACC_W];

`ifdef MUL_ACC_SAT_EN
    // once clamped, any further nonzero term carries again, so the clamp is self-holding
    assign sum = carry ? {ACC_W{1'b1}} : full[ACC_W-1:0];
`else
    assign sum = full[ACC_W-1:0];
`endif
endmodule

// File: rtl/mul_prod_accum.sv
// Multiply-accumulate stage: sums n_terms products into an ACC_W accumulator and holds the
// result until taken. Saturating arithmetic selected by MUL_ACC_SAT_EN (see mul_acc_add).
module mul_prod_accum
    import mul_prod_accum_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input logic             clk,
    input logic             rst,
    mul_prod_accum_if.slave bus
);
    logic [1:0]       state;
    logic [CNT_W-1:0] remaining;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum;
    logic             ovf_q;
    logic             carry;
    logic             xfer;

    assign bus.prod_ready = (state == ST_ACCUM);
    assign bus.busy       = (state != ST_IDLE);
    assign bus.res_valid  = (state == ST_DONE);
    assign bus.acc        = acc_q;
    assign bus.ovf        = ovf_q;

    assign xfer = bus.prod_valid & (state == ST_ACCUM);

    mul_acc_add #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc_in (acc_q),
        .prod   (bus.prod),
        .sum    (sum),
        .carry  (carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            remaining <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        acc_q     <= '0;
                        ovf_q     <= 1'b0;
                        remaining <= bus.n_terms;
                        state     <= (bus.n_terms != '0) ? ST_ACCUM : ST_DONE;
                    end
                end
                ST_ACCUM: begin
                    if (xfer) begin
                        acc_q     <= sum;
                        ovf_q     <= ovf_q | carry;
                        remaining <= remaining - 1'b1;
                        if (remaining == CNT_W'(1)) begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    // start here is deliberately dropped; a new job needs a cycle in IDLE
                    if (bus.res_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_prod_accum.sv
// Directed plus randomized jobs against a sum-of-products reference model.
module tb_mul_prod_accum;
    localparam int PROD_W  = 8;
    localparam int ACC_W   = 10;
    localparam int CNT_W   = 4;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mul_prod_accum_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();

    mul_prod_accum #(.PROD_W(PROD_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int m_phase = 0;   // 0 idle, 1 collecting, 2 result pending
    int m_rem = 0;
    int m_total = 0;   // exact unbounded sum of accepted products
    int m_xfers = 0;
    int pv [16];

    function automatic int exp_acc();
`ifdef MUL_ACC_SAT_EN
        return (m_total > ACC_MAX) ? ACC_MAX : m_total;
`else
        return m_total % (ACC_MAX + 1);
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        bit s_rst, s_start, s_pv, s_rr;
        int s_n, s_p;
        s_rst = rst; s_start = bus.start; s_pv = bus.prod_valid; s_rr = bus.res_ready;
        s_n = int'(bus.n_terms); s_p = int'(bus.prod);
        @(posedge clk);
        #1;
        if (s_rst) begin
            m_phase = 0; m_total = 0; m_rem = 0; m_xfers = 0;
        end else begin
            case (m_phase)
                0: if (s_start) begin
                    m_total = 0; m_rem = s_n; m_xfers = 0;
                    m_phase = (s_n != 0) ? 1 : 2;
                end
                1: if (s_pv) begin
                    m_total += s_p; m_rem--; m_xfers++;
                    if (m_rem == 0) m_phase = 2;
                end
                default: if (s_rr) m_phase = 0;
            endcase
        end
        chk("prod_ready", 32'(bus.prod_ready), 32'(m_phase == 1));
        chk("busy",       32'(bus.busy),       32'(m_phase != 0));
        chk("res_valid",  32'(bus.res_valid),  32'(m_phase == 2));
        chk("acc",        32'(bus.acc),        32'(exp_acc()));
        chk("ovf",        32'(bus.ovf),        32'(m_total > ACC_MAX));
    endtask

    task automatic job(input int n, input int gmin, input int gmax, input int rdelay,
                       input bit hold, input int abort_at);
        int idx = 0;
        int gap;
        int dcnt = 0;
        int cyc = 0;
        int lat = 0;
        bit aborted = 0;
        gap = int'($urandom_range(gmax, gmin));
        bus.start   = 1'b1;
        bus.n_terms = CNT_W'(n);
        while (cyc < 400) begin
            if (gap == 0 && idx < n) begin
                bus.prod_valid = 1'b1;
                bus.prod       = PROD_W'(pv[idx]);
            end else begin
                bus.prod_valid = (idx >= n) ? 1'($urandom_range(1, 0)) : 1'b0;
                bus.prod       = PROD_W'($urandom);
            end
            bus.res_ready = (m_phase == 2 && dcnt >= rdelay);
            rst = (abort_at >= 0 && m_phase == 1 && m_xfers == abort_at);
            aborted = rst;
            step();
            cyc++;
            if (!hold) bus.start = 1'b0;
            if (aborted) begin
                rst = 1'b0;
                break;
            end
            if (bus.res_valid && lat == 0) lat = cyc;
            if (m_phase == 2) dcnt++;
            if (m_phase == 0) break;
            if (m_xfers != idx) begin
                idx = m_xfers;
                gap = int'($urandom_range(gmax, gmin));
            end else if (gap > 0) begin
                gap--;
            end
        end
        if (gmax == 0 && abort_at < 0) chk("latency", 32'(lat), 32'(n + 1));
        bus.start      = 1'b0;
        bus.prod_valid = 1'b0;
        bus.res_ready  = 1'b0;
        step();
        chk("job_end_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.n_terms = '0; bus.prod = '0;
        bus.prod_valid = 1'b0; bus.res_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();

        // reset lands after two accepted terms
        for (int i = 0; i < 16; i++) pv[i] = int'($urandom_range(255, 1));
        job(5, 0, 0, 0, 1'b0, 2);

        for (int i = 0; i < 3; i++) pv[i] = 225;
        job(3, 0, 0, 2, 1'b0, -1);
        chk("t2_acc", 32'(bus.acc), 32'd675);

        pv[0] = 10; pv[1] = 20;
        job(2, 3, 3, 0, 1'b0, -1);
        chk("t3_acc", 32'(bus.acc), 32'd30);

        job(0, 0, 0, 1, 1'b0, -1);
        chk("t4_acc", 32'(bus.acc), 32'd0);

        for (int i = 0; i < 5; i++) pv[i] = 225;
        job(5, 0, 1, 1, 1'b0, -1);
`ifdef MUL_ACC_SAT_EN
        chk("t5_acc", 32'(bus.acc), 32'd1023);
`else
        chk("t5_acc", 32'(bus.acc), 32'd101);
`endif
        chk("t5_ovf", 32'(bus.ovf), 32'd1);

        // start held high throughout, result consumer slow
        for (int i = 0; i < 3; i++) pv[i] = int'($urandom_range(255, 0));
        job(3, 0, 2, 5, 1'b1, -1);

        for (int j = 0; j < 25; j++) begin
            for (int i = 0; i < 16; i++) pv[i] = int'($urandom_range(255, 0));
            job(int'($urandom_range(15, 0)), 0, int'($urandom_range(2, 0)),
                int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)), -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
